// File: rtl/prochot_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : prochot_monitor
//  Description : Receive side of the PROCHOT# interface. Synchronises each
//                CPU's open-drain PROCHOT# pin and debounces it on the 32KHz
//                tick. It separates assertion caused by our own driver from
//                external (CPU/VR) assertion. It reports live status, sticky
//                status and saturating per-CPU event counts.
//                Optional feature macro: PROCHOT_DUTY_EN adds a per-CPU duty
//                measurement (asserted ticks per window).
//  Revision    : 1.0  initial release
// ============================================================================
module prochot_monitor #(
    parameter int NUMBER_OF_CPUS = 2,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int EVT_CNT_W      = 8,
    parameter int WINDOW_TICKS   = 32768,
    parameter int DUTY_W         = 16
) (
    input  logic                                sys_clk,
    input  logic                                reset_n,
    input  logic                                t30p5us,
    input  logic [NUMBER_OF_CPUS-1:0]           prochot_n_in,
    input  logic [NUMBER_OF_CPUS-1:0]           prochot_outen,
    input  logic                                sts_clr,
    output logic [NUMBER_OF_CPUS-1:0]           prochot_active,
    output logic [NUMBER_OF_CPUS-1:0]           prochot_ext,
    output logic [NUMBER_OF_CPUS-1:0]           prochot_ext_sticky,
    output logic [NUMBER_OF_CPUS*EVT_CNT_W-1:0] prochot_evt_cnt,
    output logic [NUMBER_OF_CPUS*DUTY_W-1:0]    prochot_duty,
    output logic                                duty_valid
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL_ON  = 2'd1,
        ST_ASSERTED = 2'd2,
        ST_QUAL_OFF = 2'd3
    } state_t;

    localparam logic [3:0]           DEB_LAST = 4'(DEBOUNCE_TICKS);
    localparam logic [EVT_CNT_W-1:0] CNT_MAX  = '1;

    logic [NUMBER_OF_CPUS-1:0] pin_meta;
    logic [NUMBER_OF_CPUS-1:0] pin_sync;
    logic [NUMBER_OF_CPUS-1:0] outen_p1;
    logic [NUMBER_OF_CPUS-1:0] outen_d;

    // Two-flop pin synchroniser; outen rides an equal-length pipe so the two stay aligned
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            pin_meta <= '1;
            pin_sync <= '1;
            outen_p1 <= '0;
            outen_d  <= '0;
        end else begin
            pin_meta <= prochot_n_in;
            pin_sync <= pin_meta;
            outen_p1 <= prochot_outen;
            outen_d  <= outen_p1;
        end
    end

    for (genvar g = 0; g < NUMBER_OF_CPUS; g++) begin : g_cpu
        state_t               state, state_nxt;
        logic [3:0]           deb_cnt, deb_cnt_nxt;
        logic [3:0]           deb_inc;
        logic                 ext_cand, ext_cand_nxt;
        logic                 ext_flag, ext_flag_nxt;
        logic                 sticky, sticky_nxt;
        logic [EVT_CNT_W-1:0] evt_cnt, evt_cnt_nxt;
        logic                 evt;
        logic                 pin_low;

        assign pin_low = ~pin_sync[g];
        assign deb_inc = deb_cnt + 4'd1;

        // Debounce FSM state, qualification counter, source tracking and event statistics
        always_ff @(posedge sys_clk or negedge reset_n) begin
            if (!reset_n) begin
                state    <= ST_IDLE;
                deb_cnt  <= 4'd0;
                ext_cand <= 1'b0;
                ext_flag <= 1'b0;
                sticky   <= 1'b0;
                evt_cnt  <= '0;
            end else begin
                state    <= state_nxt;
                deb_cnt  <= deb_cnt_nxt;
                ext_cand <= ext_cand_nxt;
                ext_flag <= ext_flag_nxt;
                sticky   <= sticky_nxt;
                evt_cnt  <= evt_cnt_nxt;
            end
        end

        // Next-state decode; an event taking place in the same clk as sts_clr wins over the clear
        always_comb begin
            state_nxt    = state;
            deb_cnt_nxt  = deb_cnt;
            ext_cand_nxt = ext_cand;
            ext_flag_nxt = ext_flag;
            evt          = 1'b0;
            if (t30p5us) begin
                case (state)
                    ST_IDLE: begin
                        if (pin_low) begin
                            ext_cand_nxt = ~outen_d[g];
                            if (DEB_LAST == 4'd1) begin
                                // Single-sample debounce passes straight through qualification
                                state_nxt    = ST_ASSERTED;
                                deb_cnt_nxt  = 4'd0;
                                evt          = ~outen_d[g];
                                ext_flag_nxt = ~outen_d[g];
                            end else begin
                                state_nxt   = ST_QUAL_ON;
                                deb_cnt_nxt = 4'd1;
                            end
                        end
                    end
                    ST_QUAL_ON: begin
                        if (!pin_low) begin
                            state_nxt   = ST_IDLE;
                            deb_cnt_nxt = 4'd0;
                        end else if (deb_inc == DEB_LAST) begin
                            state_nxt    = ST_ASSERTED;
                            deb_cnt_nxt  = 4'd0;
                            evt          = ext_cand & ~outen_d[g];
                            ext_flag_nxt = ext_cand & ~outen_d[g];
                        end else begin
                            deb_cnt_nxt = deb_inc;
                        end
                    end
                    ST_ASSERTED: begin
                        if (!pin_low) begin
                            if (DEB_LAST == 4'd1) begin
                                state_nxt    = ST_IDLE;
                                deb_cnt_nxt  = 4'd0;
                                ext_flag_nxt = 1'b0;
                            end else begin
                                state_nxt   = ST_QUAL_OFF;
                                deb_cnt_nxt = 4'd1;
                            end
                        end
                    end
                    ST_QUAL_OFF: begin
                        if (pin_low) begin
                            state_nxt   = ST_ASSERTED;
                            deb_cnt_nxt = 4'd0;
                        end else if (deb_inc == DEB_LAST) begin
                            state_nxt    = ST_IDLE;
                            deb_cnt_nxt  = 4'd0;
                            ext_flag_nxt = 1'b0;
                        end else begin
                            deb_cnt_nxt = deb_inc;
                        end
                    end
                    default: begin
                        state_nxt    = ST_IDLE;
                        deb_cnt_nxt  = 4'd0;
                        ext_flag_nxt = 1'b0;
                    end
                endcase
            end
            // Our own driver becoming active at any point disqualifies the candidate
            if (outen_d[g]) begin
                ext_cand_nxt = 1'b0;
            end

            sticky_nxt  = sticky;
            evt_cnt_nxt = evt_cnt;
            if (sts_clr) begin
                sticky_nxt  = 1'b0;
                evt_cnt_nxt = '0;
            end
            if (evt) begin
                sticky_nxt = 1'b1;
                if (sts_clr) begin
                    evt_cnt_nxt = EVT_CNT_W'(1);
                end else if (evt_cnt != CNT_MAX) begin
                    evt_cnt_nxt = evt_cnt + EVT_CNT_W'(1);
                end
            end
        end

        assign prochot_active[g]     = (state == ST_ASSERTED) || (state == ST_QUAL_OFF);
        assign prochot_ext[g]        = prochot_active[g] & ext_flag;
        assign prochot_ext_sticky[g] = sticky;
        assign prochot_evt_cnt[g*EVT_CNT_W +: EVT_CNT_W] = evt_cnt;
    end

`ifdef PROCHOT_DUTY_EN
    localparam int                WIN_W    = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_TICKS - 1);

    logic [WIN_W-1:0] win_cnt;
    logic             win_term;
    logic             duty_valid_q;

    assign win_term = t30p5us && (win_cnt == WIN_LAST);

    // Free-running window of tick counts; pulse valid on the terminal tick
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt      <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            duty_valid_q <= win_term;
            if (win_term) begin
                win_cnt <= '0;
            end else if (t30p5us) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

    assign duty_valid = duty_valid_q;

    for (genvar g = 0; g < NUMBER_OF_CPUS; g++) begin : g_duty
        logic [DUTY_W-1:0] acc;
        logic [DUTY_W-1:0] duty_q;
        logic [DUTY_W:0]   sum;

        // Full-window duty equals WINDOW_TICKS, which may not fit; clamp to all-ones
        assign sum = {1'b0, acc} + (DUTY_W+1)'(prochot_active[g]);

        // Accumulate asserted ticks and publish the total at the end of each window
        always_ff @(posedge sys_clk or negedge reset_n) begin
            if (!reset_n) begin
                acc    <= '0;
                duty_q <= '0;
            end else if (win_term) begin
                duty_q <= sum[DUTY_W] ? '1 : sum[DUTY_W-1:0];
                acc    <= '0;
            end else if (t30p5us) begin
                acc <= sum[DUTY_W-1:0];
            end
        end

        assign prochot_duty[g*DUTY_W +: DUTY_W] = duty_q;
    end
`else
    assign prochot_duty = '0;
    assign duty_valid   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prochot_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prochot_monitor
//  Description : Directed self-checking bench for prochot_monitor
//                (DEBOUNCE_TICKS=4, EVT_CNT_W=8, WINDOW_TICKS=100).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prochot_monitor;

    localparam int NCPU = 2;
    localparam int CW   = 8;
    localparam int DW   = 16;

    logic            sys_clk = 1'b0;
    logic            reset_n;
    logic            t30p5us;
    logic [NCPU-1:0] prochot_n_in;
    logic [NCPU-1:0] prochot_outen;
    logic            sts_clr;
    logic [NCPU-1:0] prochot_active;
    logic [NCPU-1:0] prochot_ext;
    logic [NCPU-1:0] prochot_ext_sticky;
    logic [NCPU*CW-1:0] prochot_evt_cnt;
    logic [NCPU*DW-1:0] prochot_duty;
    logic            duty_valid;

    int total = 0;
    int bad   = 0;

    prochot_monitor #(
        .NUMBER_OF_CPUS (NCPU),
        .DEBOUNCE_TICKS (4),
        .EVT_CNT_W      (CW),
        .WINDOW_TICKS   (100),
        .DUTY_W         (DW)
    ) dut (
        .sys_clk            (sys_clk),
        .reset_n            (reset_n),
        .t30p5us            (t30p5us),
        .prochot_n_in       (prochot_n_in),
        .prochot_outen      (prochot_outen),
        .sts_clr            (sts_clr),
        .prochot_active     (prochot_active),
        .prochot_ext        (prochot_ext),
        .prochot_ext_sticky (prochot_ext_sticky),
        .prochot_evt_cnt    (prochot_evt_cnt),
        .prochot_duty       (prochot_duty),
        .duty_valid         (duty_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Three idle clks (lets the synchroniser settle) then one tick clk; returns 1ns after the tick edge
    task automatic one_tick(input logic clr);
        repeat (3) @(posedge sys_clk);
        #1;
        t30p5us = 1'b1;
        sts_clr = clr;
        @(posedge sys_clk);
        #1;
        t30p5us = 1'b0;
        sts_clr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) one_tick(1'b0);
    endtask

    task automatic ext_event0();
        prochot_n_in[0] = 1'b0;
        ticks(4);
        prochot_n_in[0] = 1'b1;
        ticks(4);
    endtask

    task automatic pulse_clr();
        sts_clr = 1'b1;
        @(posedge sys_clk);
        #1;
        sts_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        t30p5us       = 1'b0;
        prochot_n_in  = '1;
        prochot_outen = '0;
        sts_clr       = 1'b0;
        do_reset();

        check_val("rst_active", 32'(prochot_active), 0);
        check_val("rst_sticky", 32'(prochot_ext_sticky), 0);
        check_val("rst_cnt",    32'(prochot_evt_cnt), 0);

        // Test 1: external assertion on CPU0, latency boundary at tick 3 vs 4
        prochot_n_in[0] = 1'b0;
        ticks(3);
        check_val("t1_active_3ticks", 32'(prochot_active[0]), 0);
        ticks(1);
        check_val("t1_active", 32'(prochot_active[0]), 1);
        check_val("t1_ext",    32'(prochot_ext[0]), 1);
        check_val("t1_sticky", 32'(prochot_ext_sticky[0]), 1);
        check_val("t1_cnt0",   32'(prochot_evt_cnt[7:0]), 1);
        prochot_n_in[0] = 1'b1;
        ticks(3);
        check_val("t1_active_qualoff", 32'(prochot_active[0]), 1);
        ticks(1);
        check_val("t1_active_off", 32'(prochot_active[0]), 0);
        check_val("t1_sticky_hold", 32'(prochot_ext_sticky[0]), 1);
        pulse_clr();
        check_val("t1_sticky_clr", 32'(prochot_ext_sticky[0]), 0);
        check_val("t1_cnt_clr",    32'(prochot_evt_cnt[7:0]), 0);

        // Test 2: 3-tick glitch is ignored
        prochot_n_in[0] = 1'b0;
        ticks(3);
        prochot_n_in[0] = 1'b1;
        ticks(4);
        check_val("t2_active", 32'(prochot_active[0]), 0);
        check_val("t2_cnt0",   32'(prochot_evt_cnt[7:0]), 0);
        check_val("t2_sticky", 32'(prochot_ext_sticky[0]), 0);

        // Test 3: self-driven assertion on CPU1
        prochot_outen[1] = 1'b1;
        @(posedge sys_clk);
        #1;
        prochot_n_in[1] = 1'b0;
        ticks(10);
        check_val("t3_active1", 32'(prochot_active[1]), 1);
        check_val("t3_ext1",    32'(prochot_ext[1]), 0);
        check_val("t3_cnt1",    32'(prochot_evt_cnt[15:8]), 0);
        check_val("t3_sticky1", 32'(prochot_ext_sticky[1]), 0);
        prochot_n_in[1] = 1'b1;
        ticks(4);
        prochot_outen[1] = 1'b0;
        check_val("t3_active1_off", 32'(prochot_active[1]), 0);

        // Test 4: counter saturation, then clear coinciding with an event
        for (int i = 0; i < 255; i++) ext_event0();
        check_val("t4_cnt255", 32'(prochot_evt_cnt[7:0]), 255);
        for (int i = 0; i < 45; i++) ext_event0();
        check_val("t4_cnt_sat", 32'(prochot_evt_cnt[7:0]), 255);
        check_val("t4_cnt1_untouched", 32'(prochot_evt_cnt[15:8]), 0);
        prochot_n_in[0] = 1'b0;
        ticks(3);
        one_tick(1'b1);
        check_val("t4_clr_evt_cnt",    32'(prochot_evt_cnt[7:0]), 1);
        check_val("t4_clr_evt_sticky", 32'(prochot_ext_sticky[0]), 1);

        // Test 5: reset while qualifying the release
        prochot_n_in[0] = 1'b1;
        ticks(1);
        check_val("t5_qualoff_active", 32'(prochot_active[0]), 1);
        reset_n = 1'b0;
        #2;
        check_val("t5_rst_active", 32'(prochot_active), 0);
        check_val("t5_rst_ext",    32'(prochot_ext), 0);
        check_val("t5_rst_sticky", 32'(prochot_ext_sticky), 0);
        check_val("t5_rst_cnt",    32'(prochot_evt_cnt), 0);
        repeat (2) @(posedge sys_clk);
        #1;
        reset_n = 1'b1;
        ticks(6);
        check_val("t5_post_cnt",    32'(prochot_evt_cnt[7:0]), 0);
        check_val("t5_post_active", 32'(prochot_active[0]), 0);

`ifdef PROCHOT_DUTY_EN
        // Test 6: 25 asserted ticks within a 100-tick window
        do_reset();
        prochot_n_in[0] = 1'b0;
        ticks(25);
        prochot_n_in[0] = 1'b1;
        ticks(74);
        check_val("t6_valid_early", 32'(duty_valid), 0);
        ticks(1);
        check_val("t6_valid", 32'(duty_valid), 1);
        check_val("t6_duty0", 32'(prochot_duty[15:0]), 25);
        check_val("t6_duty1", 32'(prochot_duty[31:16]), 0);
        @(posedge sys_clk);
        #1;
        check_val("t6_valid_pulse", 32'(duty_valid), 0);
`else
        check_val("duty_tied", 32'(prochot_duty), 0);
        check_val("valid_tied", 32'(duty_valid), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
